// File: rtl/tdm_pkg.sv
// Shared types and sizing constants for the four-channel TDM frame recovery block.
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_t;

    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned CH_IDX_W  = 2;
    localparam int unsigned ERR_CNT_W = 8;

endpackage

// File: rtl/tdm_demux_1_to_4.sv
// Recovers 4-channel frames from a qualified serial sample stream, aligning on frame_sync
// and flagging framing violations with a saturating error count.
module tdm_demux_1_to_4
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      din,
    input  logic                  din_valid,
    input  logic                  frame_sync,
    output logic [4*WIDTH-1:0]    dout,
    output logic                  dout_valid,
    output logic [1:0]            ch_idx,
    output logic                  locked,
    output logic                  sync_err,
    output logic [7:0]            err_count
);

    localparam logic [CH_IDX_W-1:0] LAST_CH = CH_IDX_W'(NUM_CH - 1);

    tdm_state_t                             state_q, state_d;
    logic [CH_IDX_W-1:0]                    ch_idx_q, ch_idx_d;
    logic [NUM_CH-2:0][WIDTH-1:0]           shadow_q, shadow_d;
    logic [NUM_CH*WIDTH-1:0]                dout_q, dout_d;
    logic                                   dout_valid_q, dout_valid_d;
    logic                                   sync_err_q, sync_err_d;
    logic [ERR_CNT_W-1:0]                   err_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            ch_idx_q     <= '0;
            shadow_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            ch_idx_q     <= ch_idx_d;
            shadow_q     <= shadow_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sync_err_q   <= sync_err_d;
            if (sync_err_d && (err_count_q != '1))
                err_count_q <= err_count_q + 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        ch_idx_d     = ch_idx_q;
        shadow_d     = shadow_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        sync_err_d   = 1'b0;

        if (din_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        shadow_d[0] = din;
                        ch_idx_d    = CH_IDX_W'(1);
                        state_d     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync && (ch_idx_q != '0)) begin
                        // Early sync: restart the frame on this sample.
                        sync_err_d  = 1'b1;
                        shadow_d[0] = din;
                        ch_idx_d    = CH_IDX_W'(1);
                    end else if (!frame_sync && (ch_idx_q == '0)) begin
                        sync_err_d = 1'b1;
                        ch_idx_d   = '0;
                        state_d    = HUNT;
                    end else if (ch_idx_q == LAST_CH) begin
                        dout_d       = {din, shadow_q};
                        dout_valid_d = 1'b1;
                        ch_idx_d     = '0;
                    end else begin
                        shadow_d[ch_idx_q] = din;
                        ch_idx_d           = ch_idx_q + 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign ch_idx     = ch_idx_q;
    assign locked     = (state_q == LOCKED);
    assign sync_err   = sync_err_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_tdm_demux_1_to_4.sv
// Directed-vector bench for tdm_demux_1_to_4 at WIDTH=1 with hand-computed frames.
module tb_tdm_demux_1_to_4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [0:0] din = '0;
    logic       din_valid = 1'b0;
    logic       frame_sync = 1'b0;
    logic [3:0] dout;
    logic       dout_valid;
    logic [1:0] ch_idx;
    logic       locked;
    logic       sync_err;
    logic [7:0] err_count;

    int total = 0;
    int bad = 0;
    int dv_cnt = 0;
    int se_cnt = 0;
    int both_cnt = 0;

    tdm_demux_1_to_4 #(.WIDTH(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .ch_idx     (ch_idx),
        .locked     (locked),
        .sync_err   (sync_err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    // Pulse counters sample the registered outputs of the previous cycle.
    always @(posedge clk) begin
        if (dout_valid) dv_cnt = dv_cnt + 1;
        if (sync_err) se_cnt = se_cnt + 1;
        if (dout_valid && sync_err) both_cnt = both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic d, input logic fs);
        @(negedge clk);
        din        = d;
        din_valid  = 1'b1;
        frame_sync = fs;
        @(negedge clk);
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        din        = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        dv_cnt = 0;
        se_cnt = 0;
    endtask

    initial begin
        // Reset state
        idle(2);
        check("rst_dout", dout, 4'h0);
        check("rst_dv", dout_valid, 1'b0);
        check("rst_locked", locked, 1'b0);
        check("rst_err", err_count, 8'd0);
        check("rst_ch", ch_idx, 2'd0);
        check("rst_se", sync_err, 1'b0);
        rst_n = 1'b1;
        idle(1);

        // Clean frame 1,0,1,1
        clear_counts();
        send(1'b1, 1'b1);
        check("clean_lock", locked, 1'b1);
        check("clean_ch1", ch_idx, 2'd1);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        check("clean_nodv", dout_valid, 1'b0);
        send(1'b1, 1'b0);
        check("clean_dv", dout_valid, 1'b1);
        check("clean_dout", dout, 4'b1101);
        check("clean_se", sync_err, 1'b0);
        check("clean_ch0", ch_idx, 2'd0);
        idle(1);
        check("clean_dv_drop", dout_valid, 1'b0);
        check("clean_hold", dout, 4'b1101);

        // Gapped frame 0,1,1,0
        clear_counts();
        send(1'b0, 1'b1);
        idle(3);
        check("gap_ch1", ch_idx, 2'd1);
        check("gap_hold", dout, 4'b1101);
        send(1'b1, 1'b0);
        idle(3);
        check("gap_ch2", ch_idx, 2'd2);
        send(1'b1, 1'b0);
        idle(3);
        check("gap_ch3", ch_idx, 2'd3);
        send(1'b0, 1'b0);
        check("gap_dout", dout, 4'b0110);
        idle(3);
        check("gap_dv_once", dv_cnt, 1);
        check("gap_se", se_cnt, 0);

        // Early sync on the 3rd sample, which starts frame A=0,B=1,C=1,D=1
        clear_counts();
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        send(1'b0, 1'b1);
        check("early_se", sync_err, 1'b1);
        check("early_dv", dout_valid, 1'b0);
        check("early_err", err_count, 8'd1);
        check("early_ch", ch_idx, 2'd1);
        check("early_lock", locked, 1'b1);
        send(1'b1, 1'b0);
        check("early_se_drop", sync_err, 1'b0);
        send(1'b1, 1'b0);
        check("early_nodout", dout, 4'b0110);
        send(1'b1, 1'b0);
        check("early_dout", dout, 4'b1110);
        check("early_dv2", dout_valid, 1'b1);
        idle(2);
        check("early_dv_cnt", dv_cnt, 1);
        check("early_se_cnt", se_cnt, 1);

        // Missing sync on the 5th sample
        clear_counts();
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        check("miss_frame", dout, 4'b1001);
        send(1'b1, 1'b0);
        check("miss_se", sync_err, 1'b1);
        check("miss_unlock", locked, 1'b0);
        check("miss_err", err_count, 8'd2);
        check("miss_ch", ch_idx, 2'd0);
        repeat (5) send(1'b1, 1'b0);
        check("miss_hunt_lock", locked, 1'b0);
        check("miss_hunt_ch", ch_idx, 2'd0);
        check("miss_hunt_dout", dout, 4'b1001);
        send(1'b0, 1'b1);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        check("miss_relock_dout", dout, 4'b0100);
        check("miss_relock", locked, 1'b1);
        idle(2);
        check("miss_dv_cnt", dv_cnt, 2);
        check("miss_se_cnt", se_cnt, 1);

        // Reset mid-frame
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_dout", dout, 4'h0);
        check("mid_rst_lock", locked, 1'b0);
        check("mid_rst_err", err_count, 8'd0);
        check("mid_rst_ch", ch_idx, 2'd0);
        idle(2);
        rst_n = 1'b1;
        clear_counts();
        send(1'b1, 1'b0);
        check("post_rst_hunt", locked, 1'b0);
        send(1'b1, 1'b1);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        check("post_rst_nodv", dv_cnt, 0);
        send(1'b0, 1'b0);
        check("post_rst_dv", dout_valid, 1'b1);
        check("post_rst_dout", dout, 4'b0111);
        check("post_rst_err", err_count, 8'd0);

        // 300 consecutive early-sync violations
        idle(2);
        clear_counts();
        both_cnt = 0;
        send(1'b0, 1'b1);
        repeat (300) send(1'b1, 1'b1);
        idle(2);
        check("sat_se_cnt", se_cnt, 300);
        check("sat_err", err_count, 8'd255);
        check("sat_dv_cnt", dv_cnt, 0);
        check("sat_lock", locked, 1'b1);
        check("excl_dv_se", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux_1_to_4.md
TDM_DEMUX_1_TO_4 -- requirements
Module: tdm_demux_1_to_4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the bit width of one channel sample.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port din, input, WIDTH, the serial time-division sample stream.
REQ-005 The block SHALL have port din_valid, input, 1, qualifying din for one cycle.
REQ-006 The block SHALL have port frame_sync, input, 1, marking that the qualified din is channel 0; ignored when din_valid is low.
REQ-007 The block SHALL have port dout, output, 4*WIDTH, the registered recovered frame; channel n occupies bits [n*WIDTH +: WIDTH].
REQ-008 The block SHALL have port dout_valid, output, 1, a one-cycle pulse marking a new complete frame on dout.
REQ-009 The block SHALL have port ch_idx, output, 2, the channel index that the next qualified sample will fill.
REQ-010 The block SHALL have port locked, output, 1, high while the FSM is in LOCKED.
REQ-011 The block SHALL have port sync_err, output, 1, a one-cycle pulse on each framing violation.
REQ-012 The block SHALL have port err_count, output, 8, a saturating count of sync_err pulses.

Function
REQ-013 The block SHALL implement a two-state FSM: HUNT and LOCKED.
REQ-014 In HUNT, qualified samples without frame_sync SHALL be discarded with no sync_err.
REQ-015 In HUNT, a qualified sample with frame_sync SHALL be stored as channel 0, set ch_idx to 1, and enter LOCKED.
REQ-016 In LOCKED, each qualified sample SHALL be stored into shadow slot ch_idx, and ch_idx SHALL increment modulo 4.
REQ-017 On the qualified channel-3 sample, dout SHALL load {din, shadow[2], shadow[1], shadow[0]} on that clock edge, and dout_valid SHALL be high for exactly the following cycle (latency 1 clock from the channel-3 sample).
REQ-018 dout SHALL hold its value between frames; partial frames SHALL never reach dout.
REQ-019 Cycles with din_valid low SHALL leave the state, ch_idx and shadow unchanged, allowing arbitrary gaps.
REQ-020 In LOCKED, frame_sync with ch_idx != 0 (early sync) SHALL pulse sync_err, discard the partial frame, store the sample as channel 0, set ch_idx to 1, and stay LOCKED.
REQ-021 In LOCKED, a qualified sample with ch_idx == 0 and frame_sync low (missing sync) SHALL pulse sync_err, discard the sample, set ch_idx to 0, and return to HUNT.
REQ-022 In LOCKED, frame_sync with ch_idx == 0 SHALL be the normal frame start, with no error.
REQ-023 err_count SHALL increment by 1 per sync_err and saturate at 255.
REQ-024 dout_valid and sync_err SHALL never be high in the same cycle.

Reset
REQ-025 Asserting rst_n low SHALL immediately force:
  - state to HUNT
  - ch_idx to 0
  - shadow and dout to 0
  - dout_valid, sync_err, locked and err_count to 0
REQ-026 Reset asserted mid-frame SHALL discard the partial frame and produce no dout_valid.
REQ-027 Release of rst_n SHALL require a fresh frame_sync before any dout_valid.

Structure
REQ-028 Package tdm_pkg SHALL hold:
  - the state enum {HUNT, LOCKED}
  - NUM_CH = 4
  - CH_IDX_W = 2
  - ERR_CNT_W = 8
REQ-029 The block SHALL be a single module with no sub-module; FSM, counter and shadow registers are small enough to remain flat.

Verification
REQ-030 Reset then one clean frame: WIDTH=1, samples 1,0,1,1 with frame_sync on the first -> one dout_valid pulse one cycle after the 4th sample, dout=4'b1101, locked=1, sync_err=0.
REQ-031 Gapped frame: samples 0,1,1,0 with 3 idle cycles between each -> dout=4'b0110 exactly once, ch_idx holds its value through the gaps.
REQ-032 Early sync: frame_sync on the 3rd sample of a frame, followed by a full frame A,B,C,D -> sync_err one pulse, err_count=1, next dout={D,C,B,A}, no dout for the broken frame.
REQ-033 Missing sync: the 5th sample arrives without frame_sync -> sync_err pulse, locked=0, subsequent samples ignored until the next frame_sync.
REQ-034 Reset mid-frame: rst_n low after 2 samples, released, then a full frame 1,1,1,0 -> no dout_valid before that frame completes, dout=4'b0111, err_count=0.
REQ-035 Error saturation: 300 consecutive early-sync violations -> err_count stops at 255, 300 sync_err pulses observed.
